// File: rtl/aoi21_vector_sequencer.sv
// rtl/aoi21_vector_sequencer.sv - exhaustive 8-vector self-test sequencer for one AOI21 cell
//
// Drives the eight {a,b,c} input combinations 000..111 into an AOI21 cell
// (y = ~((a&b)|c)), holds each for SETTLE_CYCLES clocks, samples y_in for one
// CHECK cycle and compares it against the golden value. Reports mismatch count,
// first failing vector, a one-cycle done pulse and a sticky pass flag.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             begin a run (only honoured in IDLE)
//   y_in              output of the cell under test
//   a_out/b_out/c_out cell inputs, {a,b,c} = current vector
//   busy              run in progress
//   done              one-cycle end-of-run pulse
//   pass              last run had zero mismatches (held until next start)
//   err_count         mismatches in current/last run (0..8)
//   first_fail_vec    {a,b,c} of the first mismatching vector
//   first_fail_valid  first_fail_vec holds a captured value

module aoi21_vector_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       c_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    vec_q, vec_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    abc_q, abc_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pass_q, pass_d;
    logic [3:0]    err_q, err_d;
    logic [2:0]    ffv_q, ffv_d;
    logic          ffvalid_q, ffvalid_d;

    logic          exp_y;
    logic          mismatch;
    logic [3:0]    err_next;

    assign exp_y = ~((vec_q[2] & vec_q[1]) | vec_q[0]);
    // Case inequality so that an x or z on the sampled cell output is a failure.
    assign mismatch = (y_in !== exp_y);

    always_comb begin
        err_next = err_q;
        if (mismatch && (err_q != 4'd8)) begin
            err_next = err_q + 4'd1;
        end
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        abc_d     = abc_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pass_d    = pass_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_d     = 3'd0;
                    cnt_d     = '0;
                    // Present vector 000 right away so it gets the full settle window.
                    abc_d     = 3'd0;
                    err_d     = 4'd0;
                    ffv_d     = 3'd0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE: begin
                abc_d = vec_q;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                err_d = err_next;
                if (mismatch && !ffvalid_q) begin
                    ffv_d     = vec_q;
                    ffvalid_d = 1'b1;
                end
                if (vec_q == 3'd7) begin
                    // done and pass become visible together in the DONE cycle.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_next == 4'd0);
                    state_d = S_DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    abc_d   = vec_q + 3'd1;
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec_q     <= 3'd0;
            cnt_q     <= '0;
            abc_q     <= 3'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= 4'd0;
            ffv_q     <= 3'd0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            abc_q     <= abc_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign a_out            = abc_q[2];
    assign b_out            = abc_q[1];
    assign c_out            = abc_q[0];
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule
